// File: rtl/seq_mult_32b_pkg.sv
// Shared ALU definitions: multiplier FSM state encoding and iteration count.
package seq_mult_32b_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int ITER_COUNT = 32;

endpackage

// File: rtl/adder_32b.sv
// Unsigned adder producing a WIDTH-bit sum plus carry-out; the shift-add datapath of seq_mult_32b.
module adder_32b
  import seq_mult_32b_pkg::*;
#(
  parameter int WIDTH = ITER_COUNT
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  assign {carry, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/seq_mult_32b.sv
// Sequential shift-add unsigned multiplier: one partial product per clock, WIDTH iterations.
module seq_mult_32b
  import seq_mult_32b_pkg::*;
#(
  parameter int WIDTH = ITER_COUNT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   i0,
  input  logic [WIDTH-1:0]   i1,
  output logic [2*WIDTH-1:0] product,
  output logic               busy,
  output logic               done
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_t               state_reg, state_next;
  logic [2*WIDTH-1:0]   product_reg, product_next;
  logic [WIDTH-1:0]     mcand_reg, mcand_next;
  logic [CNT_W-1:0]     count_reg, count_next;

  logic [WIDTH-1:0]     addend;
  logic [WIDTH-1:0]     sum;
  logic                 carry;

  // The multiplier lives in the low half of product and is consumed as it shifts out.
  assign addend = product_reg[0] ? mcand_reg : '0;

  adder_32b #(
    .WIDTH(WIDTH)
  ) u_adder (
    .a     (product_reg[2*WIDTH-1:WIDTH]),
    .b     (addend),
    .sum   (sum),
    .carry (carry)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      product_reg <= '0;
      mcand_reg   <= '0;
      count_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      product_reg <= product_next;
      mcand_reg   <= mcand_next;
      count_reg   <= count_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    product_next = product_reg;
    mcand_next   = mcand_reg;
    count_next   = count_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          mcand_next   = i0;
          product_next = {{WIDTH{1'b0}}, i1};
          count_next   = '0;
          state_next   = CALC;
        end
      end
      CALC: begin
        product_next = {carry, sum, product_reg[WIDTH-1:1]};
        count_next   = count_reg + CNT_W'(1);
        if (count_reg == LAST_ITER) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign product = product_reg;
  assign busy    = (state_reg == CALC);
  assign done    = (state_reg == DONE);

endmodule

// File: tb/tb_seq_mult_32b.sv
// Scoreboard bench for seq_mult_32b: stimulus pushes expected results, a negedge monitor checks each done.
module tb_seq_mult_32b;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] i0 = '0;
  logic [31:0] i1 = '0;
  logic [63:0] product;
  logic        busy;
  logic        done;

  seq_mult_32b #(.WIDTH(32)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .i0      (i0),
    .i1      (i1),
    .product (product),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  typedef struct {
    logic [63:0] prod;
    int          at;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;
  int busy_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset) begin
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        $display("txn: done at edge %0d product=%h busy_cycles=%0d", edge_cnt, product, busy_cnt);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done at edge %0d required none", edge_cnt);
        end else begin
          e = sb.pop_front();
          check("product", product, e.prod);
          check("done_edge", 64'(edge_cnt), 64'(e.at));
          check("busy_cycles", 64'(busy_cnt), 64'd32);
        end
        busy_cnt = 0;
      end
    end
  end

  task automatic launch(input logic [31:0] a, input logic [31:0] b, output int e0);
    @(negedge clk);
    i0 = a;
    i1 = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    e0 = edge_cnt;
    start = 1'b0;
  endtask

  task automatic expect_result(input logic [63:0] p, input int at);
    exp_t e;
    e.prod = p;
    e.at = at;
    sb.push_back(e);
  endtask

  task automatic pulse_start_at(input int target, input logic [31:0] a, input logic [31:0] b);
    while (edge_cnt != target - 1) @(negedge clk);
    i0 = a;
    i1 = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending results after %0d cycles required 0", sb.size(), budget);
      sb.delete();
    end
  endtask

  initial begin
    int e0;

    // Asynchronous reset before any clock edge
    #1 reset = 1'b1;
    #1;
    check("reset_product", product, 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Basic
    launch(32'd10, 32'd15, e0);
    expect_result(64'd150, e0 + 32);
    drain(60);
    repeat (3) @(negedge clk);
    check("hold_product", product, 64'd150);

    // Maximum operands
    launch(32'hFFFF_FFFF, 32'hFFFF_FFFF, e0);
    expect_result(64'hFFFF_FFFE_0000_0001, e0 + 32);
    drain(60);

    // Zero multiplicand with ignored starts at E5 and E32
    launch(32'd0, 32'h1234_5678, e0);
    expect_result(64'd0, e0 + 32);
    pulse_start_at(e0 + 5, 32'd3, 32'd3);
    pulse_start_at(e0 + 32, 32'd3, 32'd3);
    drain(60);
    repeat (40) @(negedge clk);
    check("ignored_start_product", product, 64'd0);

    // Operands change after acceptance
    launch(32'h0001_0000, 32'h0001_0000, e0);
    expect_result(64'h0000_0001_0000_0000, e0 + 32);
    @(posedge clk);
    #1;
    i0 = 32'd7;
    i1 = 32'd7;
    drain(60);

    // Reset mid-operation: aborted, no done pulse expected
    launch(32'd10, 32'd15, e0);
    repeat (10) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("abort_product", product, 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    check("abort_idle_busy", 64'(busy), 64'd0);
    launch(32'd6, 32'd7, e0);
    expect_result(64'd42, e0 + 32);
    drain(60);

    // Back-to-back with start held high: period 34
    @(negedge clk);
    i0 = 32'd2;
    i1 = 32'd5;
    start = 1'b1;
    @(posedge clk);
    #1;
    e0 = edge_cnt;
    expect_result(64'd10, e0 + 32);
    expect_result(64'd10, e0 + 66);
    expect_result(64'd10, e0 + 100);
    while (edge_cnt != e0 + 100) @(negedge clk);
    start = 1'b0;
    drain(150);
    repeat (40) @(negedge clk);
    check("b2b_stopped_busy", 64'(busy), 64'd0);

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_mult_32b.md
SEQ_MULT_32B -- requirements
Module: seq_mult_32b

Interface
REQ-001 SHALL have the following ports, in this order:
- clk  input  1  sole clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request to begin a multiply; sampled on clk.
- i0  input  32  multiplicand, unsigned.
- i1  input  32  multiplier, unsigned.
- product  output  64  unsigned product register.
- busy  output  1  high while an iteration sequence runs.
- done  output  1  one-cycle pulse when product is valid.
REQ-002 SHALL have parameter WIDTH, default 32, giving the operand width; product width is 2*WIDTH.
REQ-003 SHALL run on one clock, clk, with reset asynchronous and active-high.

Function
REQ-004 SHALL implement a shift-add multiplier with three states: IDLE, CALC, DONE.
REQ-005 IDLE with start=1 at an edge (E0) SHALL latch i0 into an internal multiplicand register, load product <= {32'b0, i1}, clear the iteration counter, and go to CALC.
REQ-006 IDLE with start=0 SHALL hold all registers.
REQ-007 Each CALC edge SHALL compute sum = {1'b0, product[63:32]} + (product[0] ? mcand : 0) as 33 bits, then load product <= {sum, product[31:1]}.
REQ-008 The counter SHALL be 6 bits and increment once per CALC edge; the 32nd CALC edge (E32) SHALL move the state to DONE.
REQ-009 DONE SHALL last exactly one cycle, between E32 and E33, and then return to IDLE.
REQ-010 busy SHALL equal (state==CALC); done SHALL equal (state==DONE). Both are registered-state decodes with no combinational path from inputs.
REQ-011 Latency from the start-sampling edge to the rising of done SHALL be exactly 32 clock edges.
REQ-012 product SHALL hold the final result from E32 until the next accepted start.
REQ-013 start SHALL be ignored in CALC and DONE, including when asserted on the same edge as the CALC-to-DONE transition; operands SHALL not be re-latched.
REQ-014 i0 and i1 SHALL be don't-care after E0; changes to them SHALL not affect the result in progress.
REQ-015 Arithmetic SHALL be unsigned modulo 2^64; no overflow is possible and no overflow flag SHALL exist.

Reset
REQ-016 reset=1 SHALL immediately, without waiting for a clock edge, force state=IDLE, product=0, mcand=0, counter=0, busy=0 and done=0.
REQ-017 Reset asserted during CALC or DONE SHALL abort the operation with no done pulse; the first start after release SHALL behave as REQ-005.

Structure
REQ-018 State encodings (IDLE=2'd0, CALC=2'd1, DONE=2'd2) and ITER_COUNT=32 SHALL live in a shared ALU definitions header/package used by all ALU blocks.
REQ-019 The 33-bit add in REQ-007 SHALL be one sub-module instance, adder_32b, taking two 32-bit inputs and producing a 32-bit sum plus carry-out. The FSM, counter and shift logic SHALL stay in seq_mult_32b.
REQ-020 product SHALL be the only 64-bit storage; no separate multiplier register SHALL exist.

Verification
REQ-021 Basic: i0=10, i1=15, start pulse one cycle -> done pulses exactly 32 edges later with product=150; busy is high for those 32 cycles.
REQ-022 Maximum: i0=32'hFFFFFFFF, i1=32'hFFFFFFFF -> product=64'hFFFFFFFE00000001 at done.
REQ-023 Zero and ignored start: i0=0, i1=32'h12345678 -> product=0. Re-assert start with i0=3, i1=3 at E5 and at E32 -> no restart, still one done pulse, product=0.
REQ-024 Operand change: i0=32'h00010000, i1=32'h00010000; change both inputs to 7 at E1 -> product=64'h0000000100000000.
REQ-025 Reset mid-operation: assert reset at E10 between edges -> product=0, busy=0, done=0 immediately and no done pulse. After release, i0=6, i1=7 -> product=42.
REQ-026 Back-to-back: start held high continuously with i0=2, i1=5 -> a new operation starts on the first edge after DONE returns to IDLE (period 34 cycles), each done pulse showing product=10.
